lane_rot_ctrl: RTL

Sequencer for the rotation-offset stage of the permutation round. On `start` it walks lane indices 0..24 in order. For each lane it reads the lane word from the state RAM, drives the index into the shift-offset decoder (`dcder`), rotates the word left by the returned amount, and writes it back to the same address. It sits between the round controller (start/done) and the state RAM plus the offset decoder.

---
 rtl/lane_rot_pkg.sv | 18 +
 rtl/lane_rotl.sv | 21 ++
 rtl/lane_rot_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lane_rot_pkg.sv
// Shared constants and FSM state type for the lane rotation-offset sequencer.
package lane_rot_pkg;

  localparam int unsigned LANE_W    = 64;
  localparam int unsigned N_LANES   = 25;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned SHIFT_W   = 6;
  localparam int unsigned LAST_LANE = N_LANES - 1;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRot,
    StWr,
    StDone
  } state_e;

endpackage

// File: rtl/lane_rotl.sv
// Combinational left rotator; the shift amount is reduced modulo Width.
module lane_rotl #(
  parameter int unsigned Width  = 64,
  parameter int unsigned ShiftW = 6
) (
  input  logic [Width-1:0]  din,
  input  logic [ShiftW-1:0] shift,
  output logic [Width-1:0]  dout
);

  logic [2*Width-1:0] dbl;
  int unsigned        amt;

  // The upper half of the doubled word shifted left is the rotated word.
  always_comb begin
    amt  = 32'(shift) % Width;
    dbl  = {din, din} << amt;
    dout = dbl[2*Width-1:Width];
  end

endmodule

// File: rtl/lane_rot_ctrl.sv
// Rotation-offset sequencer: read, rotate by the decoded offset, write back lanes 0..N_LANES-1.
// Define LANE_ROT_PIPE_EN to overlap the read/rotate/write stages (one lane per cycle).
module lane_rot_ctrl
  import lane_rot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  dec_idx,
  input  logic [SHIFT_W-1:0] dec_shift,
  output logic              mem_rd_en,
  output logic [IDX_W-1:0]  mem_rd_addr,
  input  logic [LANE_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [IDX_W-1:0]  mem_wr_addr,
  output logic [LANE_W-1:0] mem_wr_data
);

  logic [LANE_W-1:0] rot_word;

  lane_rotl #(
    .Width (LANE_W),
    .ShiftW(SHIFT_W)
  ) u_rotl (
    .din  (mem_rd_data),
    .shift(dec_shift),
    .dout (rot_word)
  );

`ifdef LANE_ROT_PIPE_EN

  logic              rd_act_q, rot_v_q, wr_v_q, done_q;
  logic [IDX_W-1:0]  rd_idx_q, rot_idx_q, wr_idx_q;
  logic [LANE_W-1:0] data_q;
  logic              idle;

  assign idle = ~(rd_act_q | rot_v_q | wr_v_q | done_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_act_q  <= 1'b0;
      rot_v_q   <= 1'b0;
      wr_v_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_idx_q  <= '0;
      rot_idx_q <= '0;
      wr_idx_q  <= '0;
      data_q    <= '0;
    end else begin
      if (idle && start) begin
        rd_act_q <= 1'b1;
        rd_idx_q <= '0;
      end else if (rd_act_q && rd_idx_q == IDX_W'(LAST_LANE)) begin
        rd_act_q <= 1'b0;
      end else if (rd_act_q) begin
        rd_idx_q <= rd_idx_q + 1'b1;
      end
      rot_v_q   <= rd_act_q;
      rot_idx_q <= rd_idx_q;
      wr_v_q    <= rot_v_q;
      wr_idx_q  <= rot_idx_q;
      if (rot_v_q) data_q <= rot_word;
      done_q    <= wr_v_q && (wr_idx_q == IDX_W'(LAST_LANE));
    end
  end

  always_comb begin
    busy        = rd_act_q | rot_v_q | wr_v_q;
    done        = done_q;
    mem_rd_en   = rd_act_q;
    mem_rd_addr = rd_act_q ? rd_idx_q : '0;
    dec_idx     = rot_v_q ? rot_idx_q : '0;
    mem_wr_en   = wr_v_q;
    mem_wr_addr = wr_v_q ? wr_idx_q : '0;
    mem_wr_data = wr_v_q ? data_q : '0;
  end

`else

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [LANE_W-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    busy        = 1'b0;
    done        = 1'b0;
    dec_idx     = '0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRd;
          cnt_d   = '0;
        end
      end
      StRd: begin
        busy        = 1'b1;
        dec_idx     = cnt_q;
        mem_rd_en   = 1'b1;
        mem_rd_addr = cnt_q;
        state_d     = StRot;
      end
      StRot: begin
        busy    = 1'b1;
        dec_idx = cnt_q;
        data_d  = rot_word;
        state_d = StWr;
      end
      StWr: begin
        busy        = 1'b1;
        dec_idx     = cnt_q;
        mem_wr_en   = 1'b1;
        mem_wr_addr = cnt_q;
        mem_wr_data = data_q;
        if (cnt_q == IDX_W'(LAST_LANE)) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StRd;
        end
      end
      StDone: begin
        done    = 1'b1;
        dec_idx = cnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`endif

endmodule
